lsu_mem_initiator: RTL

Load/store initiator that sits in the MEM stage between the pipeline and a variable-latency, word-organised data memory. It converts a single pipeline load or store into a held request/acknowledge transaction with little-endian byte-lane enables, and stalls the pipeline until the transaction completes. It returns sign- or zero-extended load data, and flags bus timeouts and, optionally, misaligned accesses.

---
 rtl/lsu_mem_initiator_if.sv | 28 ++
 rtl/lsu_mem_initiator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator_if.sv
// ============================================================================
// Module      : lsu_mem_initiator_if
// Description : Word-organised data memory request/acknowledge bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_mem_initiator_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
// ============================================================================
// Module      : lsu_mem_initiator
// Description : MEM-stage load/store initiator driving a held req/ack memory
//               bus with byte lanes, load extension and timeout abort.
//               Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_initiator #(
    parameter int TIMEOUT = 255
) (
    input  wire         clk,
    input  wire         rst,
    input  wire         ex_valid,
    input  wire         ex_load,
    input  wire         ex_store,
    input  wire  [1:0]  ex_size,
    input  wire         ex_unsigned,
    input  wire  [31:0] ex_addr,
    input  wire  [31:0] ex_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        bus_err,
    output logic        misalign,
    lsu_mem_initiator_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [8:0] C_TMO = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lo_q, lo_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_q, misalign_d;

    logic        accept;
    logic        mis_new;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rd_sh;
    logic [31:0] ld_ext;
    logic [8:0]  cnt_inc;

    assign accept  = (state_q == S_IDLE) && ex_valid && (ex_load || ex_store);
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

`ifdef MISALIGN_TRAP_EN
    assign mis_new = ((ex_size == 2'b01) && ex_addr[0]) ||
                     (ex_size[1] && (ex_addr[1:0] != 2'b00));
`else
    assign mis_new = 1'b0;
`endif

    // Little-endian lane selection; size 2'b11 behaves as a word.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = ex_wdata;
        if (ex_size == 2'b00) begin
            be_new    = 4'b0001 << ex_addr[1:0];
            wdata_new = {4{ex_wdata[7:0]}};
        end else if (ex_size == 2'b01) begin
            be_new    = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{ex_wdata[15:0]}};
        end
    end

    always_comb begin
        rd_sh  = bus.mem_rdata;
        ld_ext = bus.mem_rdata;
        if (size_q == 2'b00) begin
            rd_sh  = bus.mem_rdata >> {lo_q, 3'b000};
            ld_ext = {{24{~uns_q & rd_sh[7]}}, rd_sh[7:0]};
        end else if (size_q == 2'b01) begin
            rd_sh  = bus.mem_rdata >> {lo_q[1], 4'b0000};
            ld_ext = {{16{~uns_q & rd_sh[15]}}, rd_sh[15:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        ld_data_d   = ld_data_q;
        ld_valid_d  = 1'b0;
        bus_err_d   = 1'b0;
        misalign_d  = 1'b0;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall  = 1'b1;
                    lo_d   = ex_addr[1:0];
                    size_d = ex_size;
                    uns_d  = ex_unsigned;
                    cnt_d  = 8'd0;
                    if (mis_new) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                        ld_data_d  = 32'd0;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ex_store;
                        mem_addr_d  = {ex_addr[31:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                cnt_d = (cnt_inc >= C_TMO) ? C_TMO[7:0] : cnt_inc[7:0];
                // An ack in the cycle the count expires still wins over the abort.
                if (bus.mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = ld_ext;
                    end
                end else if (cnt_inc >= C_TMO) begin
                    state_d    = S_DONE;
                    mem_req_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    ld_data_d  = 32'd0;
                    ld_valid_d = ~mem_we_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            lo_q        <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= 32'd0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign ld_valid      = ld_valid_q;
    assign ld_data       = ld_data_q;
    assign bus_err       = bus_err_q;
    assign misalign      = misalign_q;

endmodule

`default_nettype wire
